// File: rtl/iir_orde1_pkg.sv
// Shared definitions for the first-order IIR register block:
// register map, AXI response codes, FSM state types and the Q1.15 coefficient type.
package iir_orde1_pkg;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_A0     = 3'd1;
    localparam logic [2:0] REG_A1     = 3'd2;
    localparam logic [2:0] REG_B1     = 3'd3;
    localparam logic [2:0] REG_STATUS = 3'd4;
    localparam logic [2:0] REG_CNT    = 3'd5;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_CLEAR_BIT  = 1;
    localparam int CTRL_COMMIT_BIT = 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    typedef logic signed [15:0] coef_t;

    // Byte-lane merge of a 16-bit register under the two low write strobes.
    function automatic coef_t merge_bytes(input coef_t old_val, input logic [15:0] new_val,
                                          input logic [1:0] strb);
        coef_t v;
        v = old_val;
        if (strb[0]) v[7:0]  = new_val[7:0];
        if (strb[1]) v[15:8] = new_val[15:8];
        return v;
    endfunction

endpackage

// File: rtl/iir_coef_shadow.sv
// Shadow coefficient registers with an atomic commit into the core-facing set,
// taken on the next sample tick, or straight away while the filter is disabled.
module iir_coef_shadow
    import iir_orde1_pkg::*;
#(
    parameter logic [15:0] A0_RST = 16'd426,
    parameter logic [15:0] A1_RST = 16'd0,
    parameter logic [15:0] B1_RST = 16'd32342
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_en,
    input  logic        i_sample_tick,
    input  logic        i_wr_a0,
    input  logic        i_wr_a1,
    input  logic        i_wr_b1,
    input  logic [15:0] i_wr_data,
    input  logic [1:0]  i_wr_strb,
    input  logic        i_commit,
    output logic        o_pending,
    output logic [15:0] o_sh_a0,
    output logic [15:0] o_sh_a1,
    output logic [15:0] o_sh_b1,
    output logic [15:0] o_a0,
    output logic [15:0] o_a1,
    output logic [15:0] o_b1
);

    coef_t r_sh_a0, r_sh_a1, r_sh_b1;
    coef_t r_a0, r_a1, r_b1;
    logic  r_pending;
    logic  w_transfer;

    assign w_transfer = r_pending & (i_sample_tick | ~i_en);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sh_a0   <= A0_RST;
            r_sh_a1   <= A1_RST;
            r_sh_b1   <= B1_RST;
            r_a0      <= A0_RST;
            r_a1      <= A1_RST;
            r_b1      <= B1_RST;
            r_pending <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments mean the transfer below copies the pre-write
            // shadow when a shadow write lands on the same edge.
            if (i_wr_a0) r_sh_a0 <= merge_bytes(r_sh_a0, i_wr_data, i_wr_strb);
            if (i_wr_a1) r_sh_a1 <= merge_bytes(r_sh_a1, i_wr_data, i_wr_strb);
            if (i_wr_b1) r_sh_b1 <= merge_bytes(r_sh_b1, i_wr_data, i_wr_strb);
            if (w_transfer) begin
                r_a0 <= r_sh_a0;
                r_a1 <= r_sh_a1;
                r_b1 <= r_sh_b1;
            end
            // A fresh commit outranks the clear so a later shadow update is not lost.
            if (i_commit)        r_pending <= 1'b1;
            else if (w_transfer) r_pending <= 1'b0;
        end
    end

    assign o_pending = r_pending;
    assign o_sh_a0   = r_sh_a0;
    assign o_sh_a1   = r_sh_a1;
    assign o_sh_b1   = r_sh_b1;
    assign o_a0      = r_a0;
    assign o_a1      = r_a1;
    assign o_b1      = r_b1;

endmodule

// File: rtl/iir_orde1_axil_regs.sv
// AXI4-Lite register block for iir_orde1_core: control, shadow coefficients with
// tick-aligned commit, status and a free-running sample counter.
module iir_orde1_axil_regs
    import iir_orde1_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int A0_RST     = 426,
    parameter int A1_RST     = 0,
    parameter int B1_RST     = 32342
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   s_awaddr,
    input  logic                    s_awvalid,
    output logic                    s_awready,
    input  logic [DATA_WIDTH-1:0]   s_wdata,
    input  logic [3:0]              s_wstrb,
    input  logic                    s_wvalid,
    output logic                    s_wready,
    output logic [1:0]              s_bresp,
    output logic                    s_bvalid,
    input  logic                    s_bready,
    input  logic [ADDR_WIDTH-1:0]   s_araddr,
    input  logic                    s_arvalid,
    output logic                    s_arready,
    output logic [DATA_WIDTH-1:0]   s_rdata,
    output logic [1:0]              s_rresp,
    output logic                    s_rvalid,
    input  logic                    s_rready,
    input  logic                    sample_tick,
    output logic                    en,
    output logic                    clear_state,
    output logic [15:0]             a0,
    output logic [15:0]             a1,
    output logic [15:0]             b1
);

    localparam int IDX_W = ADDR_WIDTH - 2;

    w_state_t         r_wstate;
    logic             r_awready, r_wready, r_bvalid;
    logic [1:0]       r_bresp;
    logic [IDX_W-1:0] r_aw_idx;
    logic [15:0]      r_wdata;
    logic [1:0]       r_wstrb;

    r_state_t         r_rstate;
    logic             r_arready, r_rvalid;
    logic [1:0]       r_rresp;
    logic [31:0]      r_rdata;

    logic             r_en, r_clear_state;
    logic [31:0]      r_sample_cnt;

    logic             w_aw_hs, w_w_hs, w_do_write;
    logic [IDX_W-1:0] w_aw_idx, w_ar_idx;
    logic [15:0]      w_wdata;
    logic [1:0]       w_wstrb;
    logic             w_sel_ctrl, w_sel_a0, w_sel_a1, w_sel_b1, w_wr_ok;
    logic             w_ctrl_wr, w_clear, w_commit;
    logic [31:0]      w_rd_data;
    logic [1:0]       w_rd_resp;
    logic             w_pending;
    logic [15:0]      w_sh_a0, w_sh_a1, w_sh_b1;
    logic             w_unused;

    // Address and data may come from this cycle's handshake or from an earlier held beat.
    assign w_aw_hs    = s_awvalid & r_awready;
    assign w_w_hs     = s_wvalid & r_wready;
    assign w_aw_idx   = w_aw_hs ? s_awaddr[ADDR_WIDTH-1:2] : r_aw_idx;
    assign w_wdata    = w_w_hs ? s_wdata[15:0] : r_wdata;
    assign w_wstrb    = w_w_hs ? s_wstrb[1:0] : r_wstrb;
    assign w_do_write = (r_wstate == W_IDLE) & (w_aw_hs | ~r_awready) & (w_w_hs | ~r_wready);

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        w_sel_ctrl = 1'b0;
        w_sel_a0   = 1'b0;
        w_sel_a1   = 1'b0;
        w_sel_b1   = 1'b0;
        case (w_aw_idx)
            IDX_W'(REG_CTRL): w_sel_ctrl = 1'b1;
            IDX_W'(REG_A0):   w_sel_a0   = 1'b1;
            IDX_W'(REG_A1):   w_sel_a1   = 1'b1;
            IDX_W'(REG_B1):   w_sel_b1   = 1'b1;
            default: ;
        endcase
        w_wr_ok = w_sel_ctrl | w_sel_a0 | w_sel_a1 | w_sel_b1;
    end

    assign w_ctrl_wr = w_do_write & w_sel_ctrl & w_wstrb[0];
    assign w_clear   = w_ctrl_wr & w_wdata[CTRL_CLEAR_BIT];
    assign w_commit  = w_ctrl_wr & w_wdata[CTRL_COMMIT_BIT];

    assign w_ar_idx = s_araddr[ADDR_WIDTH-1:2];

    always_comb begin
        w_rd_data = '0;
        w_rd_resp = RESP_OKAY;
        case (w_ar_idx)
            IDX_W'(REG_CTRL):   w_rd_data = {31'b0, r_en};
            IDX_W'(REG_A0):     w_rd_data = {{16{w_sh_a0[15]}}, w_sh_a0};
            IDX_W'(REG_A1):     w_rd_data = {{16{w_sh_a1[15]}}, w_sh_a1};
            IDX_W'(REG_B1):     w_rd_data = {{16{w_sh_b1[15]}}, w_sh_b1};
            IDX_W'(REG_STATUS): w_rd_data = {31'b0, w_pending};
            IDX_W'(REG_CNT):    w_rd_data = r_sample_cnt;
            default:            w_rd_resp = RESP_SLVERR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_aw_idx  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_aw_hs) begin
                        r_aw_idx  <= s_awaddr[ADDR_WIDTH-1:2];
                        r_awready <= 1'b0;
                    end
                    if (w_w_hs) begin
                        r_wdata  <= s_wdata[15:0];
                        r_wstrb  <= s_wstrb[1:0];
                        r_wready <= 1'b0;
                    end
                    if (w_do_write) begin
                        r_bvalid  <= 1'b1;
                        r_bresp   <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b0;
                        r_wstate  <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (s_bready) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
            r_rresp   <= RESP_OKAY;
            r_rdata   <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (s_arvalid) begin
                        r_rdata   <= w_rd_data;
                        r_rresp   <= w_rd_resp;
                        r_rvalid  <= 1'b1;
                        r_arready <= 1'b0;
                        r_rstate  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (s_rready) begin
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                        r_rstate  <= R_IDLE;
                    end
                end
            endcase
        end
    end

    // CLEAR outranks the tick increment; clear_state follows the write by one edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_en          <= 1'b0;
            r_clear_state <= 1'b0;
            r_sample_cnt  <= '0;
        end else begin
            if (w_ctrl_wr) r_en <= w_wdata[CTRL_EN_BIT];
            r_clear_state <= w_clear;
            if (w_clear)                  r_sample_cnt <= '0;
            else if (sample_tick && r_en) r_sample_cnt <= r_sample_cnt + 32'd1;
        end
    end

    iir_coef_shadow #(
        .A0_RST (16'(A0_RST)),
        .A1_RST (16'(A1_RST)),
        .B1_RST (16'(B1_RST))
    ) u_coef_shadow (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_en          (r_en),
        .i_sample_tick (sample_tick),
        .i_wr_a0       (w_do_write & w_sel_a0),
        .i_wr_a1       (w_do_write & w_sel_a1),
        .i_wr_b1       (w_do_write & w_sel_b1),
        .i_wr_data     (w_wdata),
        .i_wr_strb     (w_wstrb),
        .i_commit      (w_commit),
        .o_pending     (w_pending),
        .o_sh_a0       (w_sh_a0),
        .o_sh_a1       (w_sh_a1),
        .o_sh_b1       (w_sh_b1),
        .o_a0          (a0),
        .o_a1          (a1),
        .o_b1          (b1)
    );

    assign w_unused = ^{s_awaddr[1:0], s_araddr[1:0], s_wdata[DATA_WIDTH-1:16], s_wstrb[3:2]};

    assign s_awready   = r_awready;
    assign s_wready    = r_wready;
    assign s_bvalid    = r_bvalid;
    assign s_bresp     = r_bresp;
    assign s_arready   = r_arready;
    assign s_rvalid    = r_rvalid;
    assign s_rresp     = r_rresp;
    assign s_rdata     = r_rdata;
    assign en          = r_en;
    assign clear_state = r_clear_state;

endmodule

// File: tb/tb_iir_orde1_axil_regs.sv
// Self-checking bench for iir_orde1_axil_regs: a table of register accesses followed by
// hand-written sequences for commit timing, CLEAR, error responses, counter wrap and reset.
module tb_iir_orde1_axil_regs;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic        clk;
    logic        rst_n;
    logic [4:0]  s_awaddr;
    logic        s_awvalid;
    logic        s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wvalid;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready;
    logic [4:0]  s_araddr;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready;
    logic        sample_tick;
    logic        en;
    logic        clear_state;
    logic [15:0] a0, a1, b1;

    iir_orde1_axil_regs dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_awaddr    (s_awaddr),
        .s_awvalid   (s_awvalid),
        .s_awready   (s_awready),
        .s_wdata     (s_wdata),
        .s_wstrb     (s_wstrb),
        .s_wvalid    (s_wvalid),
        .s_wready    (s_wready),
        .s_bresp     (s_bresp),
        .s_bvalid    (s_bvalid),
        .s_bready    (s_bready),
        .s_araddr    (s_araddr),
        .s_arvalid   (s_arvalid),
        .s_arready   (s_arready),
        .s_rdata     (s_rdata),
        .s_rresp     (s_rresp),
        .s_rvalid    (s_rvalid),
        .s_rready    (s_rready),
        .sample_tick (sample_tick),
        .en          (en),
        .clear_state (clear_state),
        .a0          (a0),
        .a1          (a1),
        .b1          (b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int clr_cnt  = 0;

    always @(negedge clk) if (clear_state) clr_cnt <= clr_cnt + 1;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } rd_exp_t;
    rd_exp_t sb_q[$];

    typedef struct {
        bit          wr;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;
    vec_t vecs[19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_lead, input int bready_delay,
                             output logic [1:0] resp, output int lat, output int hold);
        bit aw_done, w_done, aw_hs, w_hs;
        int c;
        @(negedge clk);
        s_awaddr  = addr;
        s_wdata   = data;
        s_wstrb   = strb;
        s_awvalid = 1'b1;
        s_wvalid  = (aw_lead == 0);
        aw_done = 1'b0;
        w_done  = 1'b0;
        c = 0;
        while (!(aw_done && w_done) && c < 50) begin
            aw_hs = s_awvalid && s_awready;
            w_hs  = s_wvalid && s_wready;
            @(negedge clk);
            c++;
            if (aw_hs) begin s_awvalid = 1'b0; aw_done = 1'b1; end
            if (w_hs)  begin s_wvalid  = 1'b0; w_done  = 1'b1; end
            if (!w_done && !s_wvalid && c >= aw_lead) s_wvalid = 1'b1;
        end
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        lat = 0;
        while (!s_bvalid && lat < 20) begin @(negedge clk); lat++; end
        check("bvalid seen", 32'(s_bvalid), 32'd1);
        hold = 0;
        for (int i = 0; i < bready_delay; i++) begin
            if (s_bvalid) hold++;
            @(negedge clk);
        end
        resp = s_bresp;
        s_bready = 1'b1;
        @(negedge clk);
        s_bready = 1'b0;
    endtask

    task automatic axi_read(input string name, input logic [4:0] addr, input logic [31:0] exp_data,
                            input logic [1:0] exp_resp, output int lat);
        rd_exp_t e;
        int w;
        sb_q.push_back('{exp_data, exp_resp});
        @(negedge clk);
        s_araddr  = addr;
        s_arvalid = 1'b1;
        w = 0;
        while (!s_arready && w < 20) begin @(negedge clk); w++; end
        @(negedge clk);
        s_arvalid = 1'b0;
        lat = 0;
        while (!s_rvalid && lat < 20) begin @(negedge clk); lat++; end
        e = sb_q.pop_front();
        check({name, " rvalid"}, 32'(s_rvalid), 32'd1);
        check({name, " rdata"}, s_rdata, e.data);
        check({name, " rresp"}, 32'(s_rresp), 32'(e.resp));
        s_rready = 1'b1;
        @(negedge clk);
        s_rready = 1'b0;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sample_tick = 1'b1;
            @(negedge clk);
            sample_tick = 1'b0;
        end
    endtask

    logic [1:0] resp;
    int lat, hold, c0;

    initial begin
        rst_n = 1'b0;
        s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
        s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0; sample_tick = 1'b0;

        vecs[0]  = '{1'b0, 5'h04, 32'h0, 4'h0, 32'h0000_01AA, OKAY};
        vecs[1]  = '{1'b0, 5'h08, 32'h0, 4'h0, 32'h0000_0000, OKAY};
        vecs[2]  = '{1'b0, 5'h0C, 32'h0, 4'h0, 32'h0000_7E56, OKAY};
        vecs[3]  = '{1'b0, 5'h10, 32'h0, 4'h0, 32'h0000_0000, OKAY};
        vecs[4]  = '{1'b0, 5'h00, 32'h0, 4'h0, 32'h0000_0000, OKAY};
        vecs[5]  = '{1'b0, 5'h14, 32'h0, 4'h0, 32'h0000_0000, OKAY};
        vecs[6]  = '{1'b1, 5'h08, 32'hFFFF_1234, 4'b0001, 32'h0, OKAY};
        vecs[7]  = '{1'b0, 5'h08, 32'h0, 4'h0, 32'h0000_0034, OKAY};
        vecs[8]  = '{1'b1, 5'h0A, 32'hABCD_9876, 4'b1110, 32'h0, OKAY};
        vecs[9]  = '{1'b0, 5'h0B, 32'h0, 4'h0, 32'hFFFF_9834, OKAY};
        vecs[10] = '{1'b1, 5'h10, 32'hFFFF_FFFF, 4'hF, 32'h0, SLVERR};
        vecs[11] = '{1'b0, 5'h10, 32'h0, 4'h0, 32'h0000_0000, OKAY};
        vecs[12] = '{1'b0, 5'h18, 32'h0, 4'h0, 32'h0000_0000, SLVERR};
        vecs[13] = '{1'b1, 5'h14, 32'h1234_5678, 4'hF, 32'h0, SLVERR};
        vecs[14] = '{1'b0, 5'h14, 32'h0, 4'h0, 32'h0000_0000, OKAY};
        vecs[15] = '{1'b1, 5'h1C, 32'h0000_0001, 4'hF, 32'h0, SLVERR};
        vecs[16] = '{1'b0, 5'h00, 32'h0, 4'h0, 32'h0000_0000, OKAY};
        vecs[17] = '{1'b1, 5'h00, 32'h0000_0001, 4'b1110, 32'h0, OKAY};
        vecs[18] = '{1'b0, 5'h00, 32'h0, 4'h0, 32'h0000_0000, OKAY};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        check("reset awready", 32'(s_awready), 32'd1);
        check("reset wready", 32'(s_wready), 32'd1);
        check("reset arready", 32'(s_arready), 32'd1);
        check("reset bvalid", 32'(s_bvalid), 32'd0);
        check("reset rvalid", 32'(s_rvalid), 32'd0);
        check("reset en", 32'(en), 32'd0);
        check("reset clear_state", 32'(clear_state), 32'd0);
        check("reset a0", 32'(a0), 32'd426);
        check("reset a1", 32'(a1), 32'd0);
        check("reset b1", 32'(b1), 32'h7E56);

        for (int i = 0; i < 19; i++) begin
            if (vecs[i].wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, 0, resp, lat, hold);
                check($sformatf("vec%0d bresp", i), 32'(resp), 32'(vecs[i].exp_resp));
                if (i == 6) check("same-cycle AW/W bvalid latency", 32'(lat), 32'd0);
            end else begin
                axi_read($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp_data, vecs[i].exp_resp, lat);
                if (i == 0) check("read rvalid latency", 32'(lat), 32'd0);
            end
        end

        // AW leads W by one cycle; bready held low for three cycles.
        axi_write(5'h04, 32'h0000_0200, 4'hF, 1, 3, resp, lat, hold);
        check("split write bvalid hold", 32'(hold), 32'd3);
        check("split write bresp", 32'(resp), 32'(OKAY));
        axi_read("A0 after split write", 5'h04, 32'h0000_0200, OKAY, lat);
        check("a0 not committed", 32'(a0), 32'd426);

        // Commit with EN=1 waits for a sample tick.
        axi_write(5'h00, 32'h1, 4'hF, 0, 0, resp, lat, hold);
        check("en set", 32'(en), 32'd1);
        axi_write(5'h0C, 32'h0000_8000, 4'h3, 0, 0, resp, lat, hold);
        axi_write(5'h00, 32'h5, 4'hF, 0, 0, resp, lat, hold);
        axi_read("STATUS pending", 5'h10, 32'h1, OKAY, lat);
        check("b1 before tick", 32'(b1), 32'h7E56);
        @(negedge clk);
        sample_tick = 1'b1;
        check("b1 during tick", 32'(b1), 32'h7E56);
        @(negedge clk);
        sample_tick = 1'b0;
        check("b1 after tick", 32'(b1), 32'h8000);
        check("a0 after tick", 32'(a0), 32'h0200);
        check("a1 after tick", 32'(a1), 32'h9834);
        axi_read("STATUS cleared", 5'h10, 32'h0, OKAY, lat);

        // Shadow write on the same edge as the commit transfer.
        axi_write(5'h04, 32'h0000_0300, 4'h3, 0, 0, resp, lat, hold);
        axi_write(5'h00, 32'h5, 4'hF, 0, 0, resp, lat, hold);
        @(negedge clk);
        s_awaddr = 5'h04; s_wdata = 32'h0000_0123; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b1; sample_tick = 1'b1;
        @(negedge clk);
        s_awvalid = 1'b0; s_wvalid = 1'b0; sample_tick = 1'b0;
        check("simul bvalid", 32'(s_bvalid), 32'd1);
        check("simul a0 takes old shadow", 32'(a0), 32'h0300);
        s_bready = 1'b1;
        @(negedge clk);
        s_bready = 1'b0;
        axi_read("simul A0 shadow", 5'h04, 32'h0000_0123, OKAY, lat);
        axi_read("simul STATUS", 5'h10, 32'h0, OKAY, lat);

        // Counter then CLEAR together with EN.
        tick_n(10);
        axi_read("CNT after 12 ticks", 5'h14, 32'd12, OKAY, lat);
        c0 = clr_cnt;
        axi_write(5'h00, 32'h3, 4'hF, 0, 0, resp, lat, hold);
        repeat (2) @(negedge clk);
        check("clear pulse width", 32'(clr_cnt - c0), 32'd1);
        axi_read("CNT after clear", 5'h14, 32'd0, OKAY, lat);
        tick_n(5);
        axi_read("CNT after 5 ticks", 5'h14, 32'd5, OKAY, lat);

        // EN=0: commit is immediate; CLEAR and COMMIT in one write.
        axi_write(5'h00, 32'h0, 4'hF, 0, 0, resp, lat, hold);
        axi_write(5'h0C, 32'h0000_1111, 4'h3, 0, 0, resp, lat, hold);
        c0 = clr_cnt;
        axi_write(5'h00, 32'h6, 4'hF, 0, 0, resp, lat, hold);
        repeat (2) @(negedge clk);
        check("clear+commit pulse", 32'(clr_cnt - c0), 32'd1);
        check("immediate commit b1", 32'(b1), 32'h1111);
        check("immediate commit a0", 32'(a0), 32'h0123);
        check("en off", 32'(en), 32'd0);
        axi_read("STATUS after immediate", 5'h10, 32'h0, OKAY, lat);
        axi_read("CNT after clear+commit", 5'h14, 32'd0, OKAY, lat);

        // Counter wrap.
        axi_write(5'h00, 32'h1, 4'hF, 0, 0, resp, lat, hold);
        @(negedge clk);
        force dut.r_sample_cnt = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.r_sample_cnt;
        axi_read("CNT forced", 5'h14, 32'hFFFF_FFFF, OKAY, lat);
        tick_n(1);
        axi_read("CNT wrap", 5'h14, 32'h0, OKAY, lat);

        // Reset while a read response is outstanding.
        @(negedge clk);
        s_araddr = 5'h04; s_arvalid = 1'b1;
        @(negedge clk);
        s_arvalid = 1'b0;
        check("pre-reset rvalid", 32'(s_rvalid), 32'd1);
        check("pre-reset rdata", s_rdata, 32'h0000_0123);
        @(negedge clk);
        check("rvalid held", 32'(s_rvalid), 32'd1);
        check("rdata held", s_rdata, 32'h0000_0123);
        rst_n = 1'b0;
        @(negedge clk);
        check("rvalid after reset", 32'(s_rvalid), 32'd0);
        check("arready after reset", 32'(s_arready), 32'd1);
        check("a0 after reset", 32'(a0), 32'd426);
        rst_n = 1'b1;
        check("en after reset", 32'(en), 32'd0);
        axi_read("A0 after reset", 5'h04, 32'h0000_01AA, OKAY, lat);
        axi_read("CNT after reset", 5'h14, 32'h0, OKAY, lat);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_checks);
        $fatal(1, "timeout");
    end

endmodule
